// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/add/shift ops plus iterative shift-add
// multiply and restoring divide, with registered result and flags.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             za,
  input  logic             ia,
  input  logic             zb,
  input  logic             ib,
  input  logic             io,
  input  logic             po,
  input  logic             use_carry,
  input  logic             carryin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carryout,
  output logic             overout,
  output logic             zero,
  output logic             neg,
  output logic             div_by_zero
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_SHL = 3'd3;
  localparam logic [2:0] OP_SHR = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;
  localparam logic [2:0] OP_DIV = 3'd6;
  localparam logic [2:0] OP_OR  = 3'd7;

  localparam logic [WIDTH-1:0] W_LIMIT  = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   CNT_INIT = SHW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_EXEC,
    S_MUL_IT,
    S_DIV_IT,
    S_POST
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [2:0]       r_op;
  logic             r_za, r_ia, r_zb, r_ib, r_io, r_po, r_uc, r_cin;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_xa, r_xb;
  logic [WIDTH-1:0] r_lo, r_hi;
  logic             r_cout, r_ovf;
  logic [SHW-1:0]   r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_madd;
  logic [WIDTH:0]   w_dshl;
  logic             w_dge;
  logic [WIDTH-1:0] w_dsub;
  logic             w_shamt_big;
  logic [WIDTH-1:0] w_final;

  assign w_sum = {1'b0, r_xa} + {1'b0, r_xb}
               + {{WIDTH{1'b0}}, r_po} + {{WIDTH{1'b0}}, r_uc & r_cin};

  // MUL keeps the product in {r_hi, r_lo}; the multiplier drains out of r_lo.
  assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_xa} : '0);

  // DIV keeps the partial remainder in r_hi and shifts quotient bits into r_lo.
  assign w_dshl = {r_hi, r_lo[WIDTH-1]};
  assign w_dge  = (w_dshl >= {1'b0, r_xb});
  assign w_dsub = w_dshl[WIDTH-1:0] - r_xb;

  assign w_shamt_big = (r_xb >= W_LIMIT);
  assign w_final     = r_lo ^ {WIDTH{r_io}};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nx = S_PREP;
      S_PREP:   w_state_nx = S_EXEC;
      S_EXEC: begin
        if (r_op == OP_MUL)      w_state_nx = S_MUL_IT;
        else if (r_op == OP_DIV) w_state_nx = S_DIV_IT;
        else                     w_state_nx = S_POST;
      end
      S_MUL_IT: if (r_cnt == '0) w_state_nx = S_POST;
      S_DIV_IT: if (r_cnt == '0) w_state_nx = S_POST;
      S_POST:   w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      carryout    <= 1'b0;
      overout     <= 1'b0;
      zero        <= 1'b0;
      neg         <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == S_IDLE && start) busy <= 1'b1;
      if (r_state == S_POST) begin
        busy        <= 1'b0;
        done        <= 1'b1;
        result      <= w_final;
        result_hi   <= r_hi;
        carryout    <= r_cout;
        overout     <= r_ovf;
        zero        <= (w_final == '0);
        neg         <= w_final[WIDTH-1];
        div_by_zero <= (r_op == OP_DIV) && (r_xb == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (start) begin
          r_op  <= op;
          r_za  <= za;
          r_ia  <= ia;
          r_zb  <= zb;
          r_ib  <= ib;
          r_io  <= io;
          r_po  <= po;
          r_uc  <= use_carry;
          r_cin <= carryin;
          r_a   <= a;
          r_b   <= b;
        end
      end
      S_PREP: begin
        r_xa <= (r_za ? '0 : r_a) ^ {WIDTH{r_ia}};
        r_xb <= (r_zb ? '0 : r_b) ^ {WIDTH{r_ib}};
      end
      S_EXEC: begin
        r_cnt  <= CNT_INIT;
        r_hi   <= '0;
        r_cout <= 1'b0;
        r_ovf  <= 1'b0;
        case (r_op)
          OP_ADD: begin
            r_lo   <= w_sum[WIDTH-1:0];
            r_cout <= w_sum[WIDTH];
            r_ovf  <= (r_xa[WIDTH-1] == r_xb[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != r_xa[WIDTH-1]);
          end
          OP_AND:  r_lo <= r_xa & r_xb;
          OP_XOR:  r_lo <= r_xa ^ r_xb;
          OP_OR:   r_lo <= r_xa | r_xb;
          OP_SHL:  r_lo <= w_shamt_big ? '0 : (r_xa << r_xb[SHW-1:0]);
          OP_SHR:  r_lo <= w_shamt_big ? '0 : (r_xa >> r_xb[SHW-1:0]);
          OP_MUL:  r_lo <= r_xb;
          OP_DIV:  r_lo <= r_xa;
          default: r_lo <= '0;
        endcase
      end
      S_MUL_IT: begin
        {r_hi, r_lo} <= {w_madd, r_lo[WIDTH-1:1]};
        r_cnt        <= r_cnt - 1'b1;
      end
      S_DIV_IT: begin
        r_hi  <= w_dge ? w_dsub : w_dshl[WIDTH-1:0];
        r_lo  <= {r_lo[WIDTH-2:0], w_dge};
        r_cnt <= r_cnt - 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed test-plan steps followed by random operations
// compared against an arithmetic reference model.
module tb_alu_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic        za, ia, zb, ib, io, po, use_carry, carryin;
  logic [15:0] a, b;
  logic        busy, done;
  logic [15:0] result, result_hi;
  logic        carryout, overout, zero, neg, div_by_zero;

  int total = 0;
  int bad   = 0;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .za(za), .ia(ia), .zb(zb), .ib(ib), .io(io), .po(po),
    .use_carry(use_carry), .carryin(carryin),
    .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .carryout(carryout), .overout(overout), .zero(zero), .neg(neg),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ctl = {za, ia, zb, ib, io, po, use_carry, carryin}
  function automatic void ref_model(input logic [2:0] f_op, input logic [7:0] ctl,
                                    input logic [15:0] f_a, input logic [15:0] f_b,
                                    output logic [15:0] e_res, output logic [15:0] e_hi,
                                    output logic e_c, output logic e_v, output logic e_z,
                                    output logic e_n, output logic e_d);
    logic [15:0] xa, xb, lo;
    int unsigned s;
    longint unsigned p;
    xa = ctl[7] ? 16'h0 : f_a;
    if (ctl[6]) xa = ~xa;
    xb = ctl[5] ? 16'h0 : f_b;
    if (ctl[4]) xb = ~xb;
    lo = 16'h0; e_hi = 16'h0; e_c = 1'b0; e_v = 1'b0; e_d = 1'b0;
    case (f_op)
      3'd0: begin
        s = 32'(xa) + 32'(xb) + 32'(ctl[2]) + 32'(ctl[1] & ctl[0]);
        lo = s[15:0];
        e_c = s[16];
        e_v = (xa[15] == xb[15]) && (lo[15] != xa[15]);
      end
      3'd1: lo = xa & xb;
      3'd2: lo = xa ^ xb;
      3'd3: lo = (xb >= 16'd16) ? 16'h0 : 16'(xa << xb);
      3'd4: lo = (xb >= 16'd16) ? 16'h0 : 16'(xa >> xb);
      3'd5: begin
        p = 64'(xa) * 64'(xb);
        lo = p[15:0];
        e_hi = p[31:16];
      end
      3'd6: begin
        if (xb == 16'h0) begin
          lo = 16'hFFFF; e_hi = xa; e_d = 1'b1;
        end else begin
          lo = xa / xb; e_hi = xa % xb;
        end
      end
      default: lo = xa | xb;
    endcase
    e_res = lo ^ {16{ctl[3]}};
    e_z = (e_res == 16'h0);
    e_n = e_res[15];
  endfunction

  task automatic run(input logic [2:0] t_op, input logic [7:0] ctl,
                     input logic [15:0] t_a, input logic [15:0] t_b, input bit extra);
    logic [15:0] e_res, e_hi;
    logic e_c, e_v, e_z, e_n, e_d;
    int lat, exp_lat, extra_dones;
    ref_model(t_op, ctl, t_a, t_b, e_res, e_hi, e_c, e_v, e_z, e_n, e_d);
    exp_lat = (t_op == 3'd5 || t_op == 3'd6) ? 19 : 3;
    @(negedge clk);
    op = t_op; {za, ia, zb, ib, io, po, use_carry, carryin} = ctl;
    a = t_a; b = t_b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op = 3'($urandom); {za, ia, zb, ib, io, po, use_carry, carryin} = 8'($urandom);
    a = 16'($urandom); b = 16'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    lat = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (extra) start = (lat == 4);
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'(exp_lat));
    check("busy_at_done", 32'(busy), 32'd0);
    check("result", 32'(result), 32'(e_res));
    check("result_hi", 32'(result_hi), 32'(e_hi));
    check("flags_cvznd", 32'({carryout, overout, zero, neg, div_by_zero}),
          32'({e_c, e_v, e_z, e_n, e_d}));
    @(posedge clk); #1;
    check("done_single", 32'(done), 32'd0);
    check("result_held", 32'(result), 32'(e_res));
    if (extra) begin
      extra_dones = 0;
      repeat (25) begin
        @(posedge clk); #1;
        if (done === 1'b1) extra_dones++;
      end
      check("no_second_op", 32'(extra_dones), 32'd0);
    end
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [7:0]  r_ctl;
    logic [15:0] r_a, r_b;
    int stray;

    rst = 1'b1; start = 1'b0; op = 3'd0;
    {za, ia, zb, ib, io, po, use_carry, carryin} = 8'h00;
    a = 16'h0; b = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({busy, done, carryout, overout, zero, neg, div_by_zero}), 32'd0);
    check("reset_result", 32'({result, result_hi}), 32'd0);
    rst = 1'b0;

    // ADD overflow into sign bit
    run(3'd0, 8'h00, 16'h7FFF, 16'h0001, 1'b0);
    check("add_const", 32'({result, overout, carryout, neg}), 32'({16'h8000, 3'b101}));
    // SUB via ib + po, then via ib + carry-in
    run(3'd0, 8'b0001_0100, 16'h0005, 16'h0003, 1'b0);
    check("sub_const", 32'({result, carryout, overout}), 32'({16'h0002, 2'b10}));
    run(3'd0, 8'b0001_0011, 16'h0005, 16'h0003, 1'b0);
    check("sub_cin_const", 32'(result), 32'h0002);
    // MUL with a stray start while busy
    run(3'd5, 8'h00, 16'hFFFF, 16'hFFFF, 1'b1);
    check("mul_const", 32'({result_hi, result}), 32'hFFFE_0001);
    run(3'd6, 8'h00, 16'd1000, 16'd7, 1'b0);
    check("div_const", 32'({result_hi, result}), 32'h0006_008E);
    run(3'd6, 8'h00, 16'h1234, 16'h0000, 1'b0);
    check("div0_const", 32'({result_hi, result, div_by_zero}), 32'({16'h1234, 16'hFFFF, 1'b1}));
    run(3'd3, 8'h00, 16'h0001, 16'h000F, 1'b0);
    check("shl15_const", 32'(result), 32'h8000);
    run(3'd3, 8'h00, 16'h0001, 16'h0010, 1'b0);
    check("shl16_const", 32'({result, zero}), 32'({16'h0000, 1'b1}));
    run(3'd4, 8'h00, 16'h8000, 16'h0004, 1'b0);
    check("shr_const", 32'(result), 32'h0800);
    run(3'd7, 8'b0000_1000, 16'h00F0, 16'h0F00, 1'b0);
    check("or_io_const", 32'(result), 32'hF00F);

    // Reset five cycles into a MUL aborts it without a done pulse
    @(negedge clk);
    op = 3'd5; {za, ia, zb, ib, io, po, use_carry, carryin} = 8'h00;
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_ctrl", 32'({busy, done, carryout, overout, zero, neg, div_by_zero}), 32'd0);
    check("abort_result", 32'({result, result_hi}), 32'd0);
    rst = 1'b0;
    stray = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done === 1'b1) stray++;
    end
    check("abort_no_done", 32'(stray), 32'd0);
    run(3'd0, 8'h00, 16'h1111, 16'h2222, 1'b0);
    check("post_abort_add", 32'(result), 32'h3333);

    for (int i = 0; i < 40; i++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_ctl = 8'($urandom);
      r_a   = 16'($urandom);
      r_b   = 16'($urandom);
      if ((r_op == 3'd3 || r_op == 3'd4) && ($urandom_range(0, 1) == 1)) begin
        r_b = 16'($urandom_range(0, 20));
        r_ctl[5:4] = 2'b00;
      end
      if (r_op == 3'd6 && ($urandom_range(0, 3) == 0)) r_ctl[5:4] = 2'b10;
      run(r_op, r_ctl, r_a, r_b, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
